buck_pwm_generator: RTL and testbench



---
 rtl/buck_pwm_generator_pkg.sv | 23 ++
 rtl/buck_pwm_generator_channel.sv | 66 ++++++
 rtl/buck_pwm_generator.sv | 80 ++++++++
 tb/tb_buck_pwm_generator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/buck_pwm_generator_pkg.sv
// Shared constants and FSM encoding for the buck PWM generator.
// Also used by the one-cycle controller for its 400-clock scaling.
package buck_pwm_generator_pkg;

  localparam int unsigned PERIOD      = 400;
  localparam int unsigned PHASE_SHIFT = 200;
  localparam int unsigned MAX_ON      = 200;
  localparam int unsigned MIN_ON      = 8;
  localparam int unsigned DEAD        = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  function automatic logic [15:0] clamp_on(input logic [15:0] req);
    logic [15:0] r;
    r = req;
    if (req < 16'(MIN_ON)) r = 16'd0;
    else if (req > 16'(MAX_ON)) r = 16'(MAX_ON);
    return r;
  endfunction

endpackage

// File: rtl/buck_pwm_generator_channel.sv
// One PWM channel: timer, on-time latch/clamp, armed bit, gate decode.
// Ports: clk_i/rst_ni, run_i, kill_i, enable_i, charge_i -> timer_o, armed_o, gate_h_o, gate_l_o.
module pwm_channel
  import buck_pwm_generator_pkg::*;
#(
  parameter logic [15:0] T_INIT = 16'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        kill_i,
  input  logic        enable_i,
  input  logic [15:0] charge_i,
  output logic [15:0] timer_o,
  output logic        armed_o,
  output logic        gate_h_o,
  output logic        gate_l_o
);

  localparam logic [15:0] P_LAST  = 16'(PERIOD - 1);
  localparam logic [15:0] L_END   = 16'(PERIOD - DEAD);

  logic [15:0] timer_q, timer_d;
  logic [15:0] on_q, on_d;
  logic        armed_q, armed_d;
  logic        gh_q, gh_d;
  logic        gl_q, gl_d;
  logic        start;
  logic [16:0] low_from;

  // Decode uses next-state on_time/armed so the period-start cycle
  // already sees the freshly latched values.
  always_comb begin
    start    = (timer_q == 16'd0);
    timer_d  = (timer_q == P_LAST) ? 16'd0 : timer_q + 16'd1;
    on_d     = start ? clamp_on(charge_i) : on_q;
    armed_d  = kill_i ? 1'b0 : (start ? enable_i : armed_q);
    low_from = {1'b0, on_d} + 17'(DEAD);
    gh_d     = run_i & armed_d & (on_d != 16'd0) & (timer_q < on_d);
    gl_d     = run_i & armed_d
             & ({1'b0, timer_q} >= low_from)
             & (timer_q < L_END);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q <= T_INIT;
      on_q    <= 16'd0;
      armed_q <= 1'b0;
      gh_q    <= 1'b0;
      gl_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      on_q    <= on_d;
      armed_q <= armed_d;
      gh_q    <= gh_d;
      gl_q    <= gl_d;
    end
  end

  assign timer_o  = timer_q;
  assign armed_o  = armed_q;
  assign gate_h_o = gh_q;
  assign gate_l_o = gl_q;

endmodule

// File: rtl/buck_pwm_generator.sv
// Two-channel interleaved buck gate-drive generator with fault shutdown.
// Ports: clk, rst_n, enable, fault, inductor_charging_time -> timers, period_start, gate_h/l, fault_latched.
module buck_pwm_generator
  import buck_pwm_generator_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault,
  input  logic [15:0] inductor_charging_time,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_4us_1,
  output logic        period_start,
  output logic [1:0]  gate_h,
  output logic [1:0]  gate_l,
  output logic        fault_latched
);

  logic [1:0] state_q, state_d;
  logic       ps_q;
  logic [1:0] armed;
  logic       run, kill;

  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (enable) state_d = ST_RUN;
        ST_RUN:   if (!enable && armed == 2'b00) state_d = ST_IDLE;
        ST_FAULT: if (!enable) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    // Gates follow the next state so a fault blanks them on this edge.
    run  = (state_d == ST_RUN);
    kill = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= (timer_buck_4us_0 == 16'(PERIOD - 1));
    end
  end

  pwm_channel #(.T_INIT(16'd0)) u_ch0 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .run_i    (run),
    .kill_i   (kill),
    .enable_i (enable),
    .charge_i (inductor_charging_time),
    .timer_o  (timer_buck_4us_0),
    .armed_o  (armed[0]),
    .gate_h_o (gate_h[0]),
    .gate_l_o (gate_l[0])
  );

  pwm_channel #(.T_INIT(16'(PHASE_SHIFT))) u_ch1 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .run_i    (run),
    .kill_i   (kill),
    .enable_i (enable),
    .charge_i (inductor_charging_time),
    .timer_o  (timer_buck_4us_1),
    .armed_o  (armed[1]),
    .gate_h_o (gate_h[1]),
    .gate_l_o (gate_l[1])
  );

  assign period_start  = ps_q;
  assign fault_latched = (state_q == ST_FAULT);

endmodule

// File: tb/tb_buck_pwm_generator.sv
// Self-checking bench for buck_pwm_generator.
// Reference model works from cycle count since reset and per-period records.
module tb_buck_pwm_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic [15:0] ict = 16'd0;
  logic [15:0] t0_o, t1_o;
  logic        ps_o, fl_o;
  logic [1:0]  gh_o, gl_o;

  int checks = 0;
  int errors = 0;

  buck_pwm_generator dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .fault                  (fault),
    .inductor_charging_time (ict),
    .timer_buck_4us_0       (t0_o),
    .timer_buck_4us_1       (t1_o),
    .period_start           (ps_o),
    .gate_h                 (gh_o),
    .gate_l                 (gl_o),
    .fault_latched          (fl_o)
  );

  always #5 clk = ~clk;

  // model: 0=idle 1=run 2=fault
  int n = 0;
  int st = 0;
  int on_m[2];
  bit arm_m[2];
  bit gh_m[2];
  bit gl_m[2];
  bit ps_m = 0;

  function automatic int clampv(int r);
    if (r < 8) return 0;
    if (r > 200) return 200;
    return r;
  endfunction

  task automatic model_edge();
    int nst;
    int t;
    if (!rst_n) begin
      n = 0; st = 0; ps_m = 0;
      for (int c = 0; c < 2; c++) begin
        on_m[c] = 0; arm_m[c] = 0; gh_m[c] = 0; gl_m[c] = 0;
      end
      return;
    end
    nst = st;
    if (fault) nst = 2;
    else if (st == 0 && enable) nst = 1;
    else if (st == 1 && !enable && !arm_m[0] && !arm_m[1]) nst = 0;
    else if (st == 2 && !enable) nst = 0;
    for (int c = 0; c < 2; c++) begin
      t = (n + c * 200) % 400;
      if (t == 0) begin
        on_m[c] = clampv(int'(ict));
        arm_m[c] = enable;
      end
      if (nst == 2) arm_m[c] = 0;
      gh_m[c] = (nst == 1) && arm_m[c] && on_m[c] != 0 && t < on_m[c];
      gl_m[c] = (nst == 1) && arm_m[c] && t >= on_m[c] + 10 && t < 390;
    end
    st = nst;
    n++;
    ps_m = (n % 400 == 0);
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("timer0", int'(t0_o), n % 400);
    chk("timer1", int'(t1_o), (n + 200) % 400);
    chk("period_start", int'(ps_o), int'(ps_m));
    chk("fault_latched", int'(fl_o), int'(st == 2));
    chk("gate_h", int'(gh_o), int'({gh_m[1], gh_m[0]}));
    chk("gate_l", int'(gl_o), int'({gl_m[1], gl_m[0]}));
    chk("no_overlap", int'(gh_o & gl_o), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic until_t0(int x);
    int guard;
    guard = 0;
    while (n % 400 != x && guard < 400) begin
      step();
      guard++;
    end
  endtask

  // Width of ch0 pulses over one full period in steady state.
  task automatic width(string tag, int exp_h, int exp_l);
    int ch, cl;
    ch = 0; cl = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      ch += int'(gh_o[0]);
      cl += int'(gl_o[0]);
    end
    chk({tag, "_h_width"}, ch, exp_h);
    chk({tag, "_l_width"}, cl, exp_l);
  endtask

  initial begin
    @(negedge clk);
    rst_n = 0;
    steps(3);
    rst_n = 1;

    // free-running timers, gates idle
    for (int i = 0; i < 820; i++) begin
      ict = 16'($urandom_range(0, 400));
      step();
    end

    enable = 1; ict = 16'd120;
    steps(400);
    width("ict120", 120, 260);
    ict = 16'd350;
    steps(400);
    width("ict350", 200, 180);
    ict = 16'd5;
    steps(400);
    width("ict5", 0, 380);
    ict = 16'd8;
    steps(400);
    width("ict8", 8, 372);
    ict = 16'd200;
    steps(400);
    width("ict200", 200, 180);

    // mid-period change
    ict = 16'd100;
    until_t0(0);
    steps(400);
    until_t0(50);
    ict = 16'd150;
    steps(800);

    // fault while gate_h high
    ict = 16'd120;
    until_t0(0);
    until_t0(60);
    fault = 1;
    step();
    chk("fault_gates_off", int'(gh_o | gl_o), 0);
    chk("fault_latch_set", int'(fl_o), 1);
    steps(5);
    fault = 0;
    steps(300);
    enable = 0;
    steps(5);
    enable = 1;
    steps(900);

    // enable drop mid-period
    until_t0(100);
    enable = 0;
    steps(800);
    chk("drop_idle_gates", int'(gh_o | gl_o), 0);

    // randomized phase
    enable = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) ict = 16'($urandom_range(0, 400));
      if ($urandom_range(0, 700) == 0) enable = ~enable;
      if (fault) fault = ($urandom_range(0, 3) != 0);
      else fault = ($urandom_range(0, 1500) == 0);
      step();
    end
    fault = 0;
    enable = 1;
    ict = 16'd120;
    steps(900);

    // reset mid-pulse
    until_t0(30);
    rst_n = 0;
    step();
    chk("rst_gates", int'(gh_o | gl_o), 0);
    chk("rst_t1", int'(t1_o), 200);
    rst_n = 1;
    steps(900);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
